// File: rtl/register_file.sv
`default_nettype none
// ----------------------------------------------------------------------------
// register_file : 32-entry register file, x0 hardwired to zero,
//                 two combinational read ports with write-through bypass.
// Revision      : 1.0
// ----------------------------------------------------------------------------
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  regWrite,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] rd_data,
  input  logic [ADDR_WIDTH-1:0] rs1_data,
  input  logic [ADDR_WIDTH-1:0] rs2_data,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int c_NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [c_NUM_REGS];
  logic                  w_write_en;
  logic                  w_bypass1;
  logic                  w_bypass2;

  // Entry 0 is only ever reset, never written, so it always reads as zero.
  assign w_write_en = reset && regWrite && (rd_data != '0);
  assign w_bypass1  = w_write_en && (rs1_data == rd_data);
  assign w_bypass2  = w_write_en && (rs2_data == rd_data);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_write_en) begin
      r_regs[rd_data] <= write_data;
    end
  end

  // Outputs are forced to zero during reset so nothing leaks past the async clear.
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (reset) begin
      read_data1 = w_bypass1 ? write_data : r_regs[rs1_data];
      read_data2 = w_bypass2 ? write_data : r_regs[rs2_data];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_register_file : directed, table-driven self-checking bench for register_file.
// Revision         : 1.0
// ----------------------------------------------------------------------------
module tb_register_file;

  logic        clk;
  logic        reset;
  logic        regWrite;
  logic [31:0] write_data;
  logic [4:0]  rd_data;
  logic [4:0]  rs1_data;
  logic [4:0]  rs2_data;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int n_cmp;
  int n_bad;

  register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .regWrite   (regWrite),
    .write_data (write_data),
    .rd_data    (rd_data),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    regWrite   = we;
    rd_data    = rd;
    write_data = wd;
    rs1_data   = rs1;
    rs2_data   = rs2;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // Inputs applied after a negedge; checked 1 time unit later; write lands at next posedge.
    vecs[0]  = '{1'b1, 5'd10, 32'h12345678, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd10, 5'd10, 32'h12345678, 32'h12345678};
    vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd10, 32'h0,        32'h12345678};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
    vecs[4]  = '{1'b1, 5'd3,  32'h00000001, 5'd3,  5'd0,  32'h00000001, 32'h0};
    vecs[5]  = '{1'b1, 5'd3,  32'hA5A5A5A5, 5'd0,  5'd3,  32'h0,        32'hA5A5A5A5};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[7]  = '{1'b1, 5'd7,  32'h00000055, 5'd3,  5'd7,  32'hA5A5A5A5, 32'h00000055};
    vecs[8]  = '{1'b0, 5'd7,  32'h00000099, 5'd7,  5'd7,  32'h00000055, 32'h00000055};
    vecs[9]  = '{1'b0, 5'd7,  32'h00000099, 5'd7,  5'd10, 32'h00000055, 32'h12345678};
    vecs[10] = '{1'b1, 5'd31, 32'h80000001, 5'd31, 5'd31, 32'h80000001, 32'h80000001};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd3,  32'h80000001, 32'hA5A5A5A5};
    vecs[12] = '{1'b1, 5'd10, 32'hCAFEF00D, 5'd10, 5'd0,  32'hCAFEF00D, 32'h0};
    vecs[13] = '{1'b0, 5'd0,  32'h0,        5'd10, 5'd7,  32'hCAFEF00D, 32'h00000055};

    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd10);
    reset = 1'b0;
    #1;
    check("reset rd1", read_data1, 32'h0);
    check("reset rd2", read_data2, 32'h0);

    // Write attempted while reset is held must not stick.
    @(negedge clk);
    drive(1'b1, 5'd4, 32'h11111111, 5'd4, 5'd4);
    #1;
    check("reset bypass off", read_data1, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd0);
    #1;
    check("write under reset lost", read_data1, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].rd, vecs[i].wd, vecs[i].rs1, vecs[i].rs2);
      #1;
      check($sformatf("vec%0d rd1", i), read_data1, vecs[i].e1);
      check($sformatf("vec%0d rd2", i), read_data2, vecs[i].e2);
    end

    // Async clear between edges, with no clock edge needed.
    @(negedge clk);
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd10);
    #1;
    check("preload x5", read_data1, 32'hDEADBEEF);
    #1;
    reset = 1'b0;
    #1;
    check("async clr rd1", read_data1, 32'h0);
    check("async clr rd2", read_data2, 32'h0);

    // Reset coinciding with a write: reset wins.
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 5'd6, 32'h0BADF00D, 5'd6, 5'd6);
    #1;
    check("bypass before rst", read_data2, 32'h0BADF00D);
    #2;
    reset = 1'b0;
    #1;
    check("rst kills bypass", read_data1, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd6, 5'd5);
    #1;
    check("x6 lost", read_data1, 32'h0);
    check("x5 cleared", read_data2, 32'h0);
    rs1_data = 5'd31;
    rs2_data = 5'd10;
    #1;
    check("x31 cleared", read_data1, 32'h0);
    check("x10 cleared", read_data2, 32'h0);

    // Full sweep: x_i = i * 0x01010101, read mirrored pairs.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      #1;
      check($sformatf("sweep rs1=%0d", i), read_data1, 32'(i) * 32'h01010101);
      check($sformatf("sweep rs2=%0d", 31 - i), read_data2, 32'(31 - i) * 32'h01010101);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 32, width of each register and data port.
REQ-002 The block SHALL expose parameter ADDR_WIDTH, default 5, register index width (2**ADDR_WIDTH = 32 entries).
REQ-003 The block SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port regWrite, input, 1, write enable.
REQ-006 The block SHALL have port write_data, input, DATA_WIDTH, data to write.
REQ-007 The block SHALL have port rd_data, input, ADDR_WIDTH, destination register index.
REQ-008 The block SHALL have port rs1_data, input, ADDR_WIDTH, source register 1 index.
REQ-009 The block SHALL have port rs2_data, input, ADDR_WIDTH, source register 2 index.
REQ-010 The block SHALL have port read_data1, output, DATA_WIDTH, contents of register rs1_data.
REQ-011 The block SHALL have port read_data2, output, DATA_WIDTH, contents of register rs2_data.

Function
REQ-012 The block SHALL hold 32 general registers x0..x31, each DATA_WIDTH bits.
REQ-013 x0 SHALL read as 0 at all times; writes to index 0 SHALL be discarded.
REQ-014 Write: on rising clk with reset high, regWrite=1 and rd_data!=0, register[rd_data] SHALL take write_data.
REQ-015 With regWrite=0, no register SHALL change.
REQ-016 Reads SHALL be combinational, zero-cycle latency: read_dataN reflects the addressed register in the same cycle.
REQ-017 Write-through bypass: if regWrite=1, reset high, rd_data!=0 and rs1_data==rd_data, read_data1 SHALL equal write_data combinationally in that cycle; same rule for rs2_data/read_data2.
REQ-018 When both read ports address the same register, both outputs SHALL carry identical values, bypass included.
REQ-019 Without bypass conditions, read_dataN SHALL show the register value stored at the most recent rising edge.
REQ-020 Write data SHALL be stored unmodified at full DATA_WIDTH; no sign or zero extension.
REQ-021 Outputs SHALL never be X when inputs are known; all 32 entries SHALL be defined after reset.

Reset
REQ-022 While reset=0, all registers x1..x31 SHALL be asynchronously cleared to 0, independent of clk.
REQ-023 While reset=0, read_data1 and read_data2 SHALL be 0, bypass disabled, and writes ignored.
REQ-024 On reset deassertion (0->1), the first write SHALL occur at the next rising clk with regWrite=1.
REQ-025 Reset asserted mid-operation, including in the same cycle as a write, SHALL win: the write is lost and all entries read 0.

Verification
REQ-026 Reset clears: preload x5=0xDEADBEEF, drop reset between edges -> read_data1 (rs1_data=5) = 0 immediately, without a clock edge.
REQ-027 Write/read: regWrite=1, rd_data=10, write_data=0x12345678, clock; then regWrite=0, rs1_data=10, rs2_data=10 -> both outputs 0x12345678.
REQ-028 x0 protection: regWrite=1, rd_data=0, write_data=0xFFFFFFFF, clock; rs1_data=0 -> read_data1=0.
REQ-029 Bypass: x3=0x1; same cycle regWrite=1, rd_data=3, write_data=0xA5A5A5A5, rs2_data=3 -> read_data2=0xA5A5A5A5 before the edge, and still after it.
REQ-030 Write disable: x7=0x55; regWrite=0, rd_data=7, write_data=0x99, clock -> read_data1 (rs1_data=7) = 0x55.
REQ-031 Full sweep: write x1..x31 with value index*0x01010101, read all pairs (rs1_data=i, rs2_data=31-i) -> matching values, x0 = 0.
